// File: rtl/bitwise_op_pkg.sv
// Shared types and helpers for the pipelined bitwise logic unit.
//   op_e      : per-transaction operation select (AND/OR/XOR/XNOR)
//   popcount(): number of set bits in a vector of up to POP_MAX_W bits
package bitwise_op_pkg;

  typedef enum logic [1:0] {
    OP_AND  = 2'b00,
    OP_OR   = 2'b01,
    OP_XOR  = 2'b10,
    OP_XNOR = 2'b11
  } op_e;

  // Callers zero-extend their operand to this width; constant folding keeps
  // only the bits that actually exist at the call site.
  localparam int unsigned POP_MAX_W = 1024;

  function automatic int unsigned popcount(input logic [POP_MAX_W-1:0] v);
    int unsigned n;
    n = 0;
    for (int unsigned i = 0; i < POP_MAX_W; i++) begin
      if (v[i]) n++;
    end
    return n;
  endfunction

endpackage

// File: rtl/bitwise_op_if.sv
// Handshake/data bundle for one bitwise_op_pipe instance.
//   clk        : clock (interface port)
//   driver     : drives reset, operand beat and out_ready; observes in_ready
//   monitor    : observes every signal
interface bitwise_op_if #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input logic clk
);
  localparam int unsigned POP_W = $clog2(WIDTH + 1);

  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [1:0]       in_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_y;
  logic [POP_W-1:0] out_pop;
  logic             out_zero;
  logic [CNT_W-1:0] txn_count;

  modport driver (
    input  clk, in_ready,
    output rst_n, in_valid, in_a, in_b, in_op, out_ready
  );

  modport monitor (
    input clk, rst_n, in_valid, in_ready, in_a, in_b, in_op,
          out_valid, out_ready, out_y, out_pop, out_zero, txn_count
  );

endinterface

// File: rtl/bitwise_op_stage.sv
// One register stage of the bitwise pipe carrying {valid, y, pop, zero}.
//   clk, rst_n            : clock, async active-low reset
//   up_valid/up_ready     : handshake with the previous stage (or the input)
//   up_y/up_pop/up_zero   : incoming result, popcount and zero flag
//   dn_valid/dn_ready     : handshake with the next stage (or the consumer)
//   dn_y/dn_pop/dn_zero   : registered result, popcount and zero flag
module bitwise_op_stage #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned POP_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             up_valid,
  output logic             up_ready,
  input  logic [WIDTH-1:0] up_y,
  input  logic [POP_W-1:0] up_pop,
  input  logic             up_zero,
  output logic             dn_valid,
  input  logic             dn_ready,
  output logic [WIDTH-1:0] dn_y,
  output logic [POP_W-1:0] dn_pop,
  output logic             dn_zero
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] y_q;
  logic [POP_W-1:0] pop_q;
  logic             zero_q;
  logic             load;

  always_comb begin
    // Room exists when empty or when the held beat leaves this cycle, so
    // empty stages never hold up the ones behind them.
    up_ready = !valid_q || dn_ready;
    load     = up_valid && up_ready;
    valid_d  = up_ready ? up_valid : valid_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      y_q     <= '0;
      pop_q   <= '0;
      zero_q  <= 1'b1;
    end else begin
      valid_q <= valid_d;
      if (load) begin
        y_q    <= up_y;
        pop_q  <= up_pop;
        zero_q <= up_zero;
      end
    end
  end

  assign dn_valid = valid_q;
  assign dn_y     = y_q;
  assign dn_pop   = pop_q;
  assign dn_zero  = zero_q;

endmodule

// File: rtl/bitwise_op_pipe.sv
// Pipelined bitwise logic unit: y = op(in_a, in_b) over PIPE_DEPTH stages with
// valid/ready flow control, plus popcount, zero flag and an accept counter.
//   clk, rst_n            : clock, async active-low reset
//   in_valid/in_ready     : operand beat handshake (in_ready depends on out_ready)
//   in_a, in_b, in_op     : operands and op select (op_e encoding)
//   out_valid/out_ready   : result beat handshake
//   out_y/out_pop/out_zero: result, number of set bits, result == 0
//   txn_count             : accepted beats modulo 2^CNT_W
module bitwise_op_pipe
  import bitwise_op_pkg::*;
#(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned PIPE_DEPTH = 2,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_a,
  input  logic [WIDTH-1:0]           in_b,
  input  logic [1:0]                 in_op,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_y,
  output logic [$clog2(WIDTH+1)-1:0] out_pop,
  output logic                       out_zero,
  output logic [CNT_W-1:0]           txn_count
);

  localparam int unsigned POP_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] y_in;
  logic [POP_W-1:0] pop_in;
  logic             zero_in;
  logic [CNT_W-1:0] txn_count_q, txn_count_d;

  always_comb begin
    y_in = '0;
    case (op_e'(in_op))
      OP_AND:  y_in = in_a & in_b;
      OP_OR:   y_in = in_a | in_b;
      OP_XOR:  y_in = in_a ^ in_b;
      OP_XNOR: y_in = ~(in_a ^ in_b);
      default: y_in = '0;
    endcase
    pop_in  = POP_W'(popcount(POP_MAX_W'(y_in)));
    zero_in = (y_in == '0);
  end

  always_comb begin
    txn_count_d = txn_count_q;
    if (in_valid && in_ready) txn_count_d = txn_count_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) txn_count_q <= '0;
    else        txn_count_q <= txn_count_d;
  end

  assign txn_count = txn_count_q;

  // Each stage keeps its link signals in its own scope; the ready chain runs
  // from the last stage back to in_ready without a self-referencing vector.
  for (genvar k = 0; k < PIPE_DEPTH; k++) begin : g_st
    logic             up_vld, up_rdy, up_zero;
    logic [WIDTH-1:0] up_y;
    logic [POP_W-1:0] up_pop;
    logic             dn_vld, dn_rdy, dn_zero;
    logic [WIDTH-1:0] dn_y;
    logic [POP_W-1:0] dn_pop;

    if (k == 0) begin : g_src
      assign up_vld  = in_valid;
      assign up_y    = y_in;
      assign up_pop  = pop_in;
      assign up_zero = zero_in;
    end else begin : g_link
      assign up_vld  = g_st[k-1].dn_vld;
      assign up_y    = g_st[k-1].dn_y;
      assign up_pop  = g_st[k-1].dn_pop;
      assign up_zero = g_st[k-1].dn_zero;
    end

    if (k == PIPE_DEPTH - 1) begin : g_sink
      assign dn_rdy = out_ready;
    end else begin : g_next
      assign dn_rdy = g_st[k+1].up_rdy;
    end

    bitwise_op_stage #(
      .WIDTH (WIDTH),
      .POP_W (POP_W)
    ) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .up_valid (up_vld),
      .up_ready (up_rdy),
      .up_y     (up_y),
      .up_pop   (up_pop),
      .up_zero  (up_zero),
      .dn_valid (dn_vld),
      .dn_ready (dn_rdy),
      .dn_y     (dn_y),
      .dn_pop   (dn_pop),
      .dn_zero  (dn_zero)
    );
  end

  assign in_ready  = g_st[0].up_rdy;
  assign out_valid = g_st[PIPE_DEPTH-1].dn_vld;
  assign out_y     = g_st[PIPE_DEPTH-1].dn_y;
  assign out_pop   = g_st[PIPE_DEPTH-1].dn_pop;
  assign out_zero  = g_st[PIPE_DEPTH-1].dn_zero;

endmodule

// File: tb/tb_bitwise_op_pipe.sv
// Bench for bitwise_op_pipe: directed checks on a WIDTH=4/PIPE_DEPTH=2/CNT_W=3
// instance, random sweeps on WIDTH=37 with PIPE_DEPTH=1 and 4, all against a
// queue-based reference model that runs on every falling clock edge.
module tb_bitwise_op_pipe;

  localparam int unsigned NCFG = 3;
  localparam int unsigned CFG_W [NCFG] = '{4, 37, 37};
  localparam int unsigned CFG_D [NCFG] = '{2, 1, 4};
  localparam int unsigned CFG_C [NCFG] = '{3, 16, 16};
  localparam int unsigned SWEEP_BEATS = 10000;

  localparam logic [1:0] T2_OP  [4] = '{2'd2, 2'd0, 2'd1, 2'd3};
  localparam logic [3:0] T2_Y   [4] = '{4'b1000, 4'b0100, 4'b1100, 4'b0111};
  localparam logic [2:0] T2_POP [4] = '{3'd1, 3'd1, 3'd2, 3'd3};
  localparam logic [3:0] T3_A   [5] = '{4'h3, 4'h5, 4'h9, 4'hF, 4'h0};
  localparam logic [3:0] T3_B   [5] = '{4'h5, 4'h5, 4'h6, 4'hA, 4'h7};
  localparam logic [1:0] T3_OP  [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  int unsigned sweeps_done = 0;

  logic       m_rst_n, m_in_valid, m_out_ready;
  logic [3:0] m_a, m_b;
  logic [1:0] m_op;
  logic       m_in_ready, m_out_valid, m_out_zero;
  logic [3:0] m_y;
  logic [2:0] m_pop, m_cnt;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  for (genvar gi = 0; gi < NCFG; gi++) begin : g_cfg
    localparam int unsigned W = CFG_W[gi];
    localparam int unsigned D = CFG_D[gi];
    localparam int unsigned C = CFG_C[gi];

    bitwise_op_if #(.WIDTH(W), .CNT_W(C)) bus (.clk(clk));

    bitwise_op_pipe #(.WIDTH(W), .PIPE_DEPTH(D), .CNT_W(C)) dut (
      .clk       (clk),
      .rst_n     (bus.rst_n),
      .in_valid  (bus.in_valid),
      .in_ready  (bus.in_ready),
      .in_a      (bus.in_a),
      .in_b      (bus.in_b),
      .in_op     (bus.in_op),
      .out_valid (bus.out_valid),
      .out_ready (bus.out_ready),
      .out_y     (bus.out_y),
      .out_pop   (bus.out_pop),
      .out_zero  (bus.out_zero),
      .txn_count (bus.txn_count)
    );

    logic [W-1:0] exp_q [$];
    logic [C-1:0] exp_cnt = '0;
    int unsigned  n_emit = 0;
    logic         prev_stall = 1'b0;

    function automatic logic [W-1:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [1:0] op);
      case (op)
        2'd0:    return a & b;
        2'd1:    return a | b;
        2'd2:    return a ^ b;
        default: return ~(a ^ b);
      endcase
    endfunction

    // Inputs change only just after a rising edge, so what is seen here is
    // exactly what the next rising edge will act on.
    always @(negedge clk or negedge bus.rst_n) begin
      if (!bus.rst_n) begin
        exp_q.delete();
        exp_cnt    = '0;
        prev_stall = 1'b0;
      end else begin
        check($sformatf("cfg%0d txn_count", gi), 64'(bus.txn_count), 64'(exp_cnt));
        check($sformatf("cfg%0d in_ready", gi), 64'(bus.in_ready),
              64'((exp_q.size() < int'(D)) || bus.out_ready));
        if (prev_stall)
          check($sformatf("cfg%0d valid_held", gi), 64'(bus.out_valid), 64'd1);
        if (bus.out_valid) begin
          if (exp_q.size() == 0) begin
            check($sformatf("cfg%0d unexpected_beat", gi), 64'(bus.out_valid), 64'd0);
          end else begin
            check($sformatf("cfg%0d out_y", gi), 64'(bus.out_y), 64'(exp_q[0]));
            check($sformatf("cfg%0d out_pop", gi), 64'(bus.out_pop), 64'($countones(exp_q[0])));
            check($sformatf("cfg%0d out_zero", gi), 64'(bus.out_zero), 64'(exp_q[0] == '0));
            if (bus.out_ready) begin
              void'(exp_q.pop_front());
              n_emit++;
            end
          end
        end
        prev_stall = bus.out_valid && !bus.out_ready;
        if (bus.in_valid && bus.in_ready) begin
          exp_q.push_back(ref_op(bus.in_a, bus.in_b, bus.in_op));
          exp_cnt++;
        end
      end
    end

    if (gi == 0) begin : g_main
      assign bus.rst_n     = m_rst_n;
      assign bus.in_valid  = m_in_valid;
      assign bus.in_a      = m_a;
      assign bus.in_b      = m_b;
      assign bus.in_op     = m_op;
      assign bus.out_ready = m_out_ready;
      assign m_in_ready    = bus.in_ready;
      assign m_out_valid   = bus.out_valid;
      assign m_y           = bus.out_y;
      assign m_pop         = bus.out_pop;
      assign m_out_zero    = bus.out_zero;
      assign m_cnt         = bus.txn_count;
    end else begin : g_rand
      initial begin
        int unsigned cyc;
        cyc = 0;
        bus.rst_n     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_op     = 2'd0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 bus.rst_n = 1'b1;
        while (n_emit < SWEEP_BEATS && cyc < 60000) begin
          bus.in_valid  = ($urandom_range(0, 3) != 0);
          bus.in_a      = W'({$urandom(), $urandom()});
          bus.in_b      = W'({$urandom(), $urandom()});
          bus.in_op     = 2'($urandom_range(0, 3));
          bus.out_ready = ($urandom_range(0, 9) < 7);
          step();
          cyc++;
        end
        check($sformatf("cfg%0d sweep_beats", gi), 64'(n_emit >= SWEEP_BEATS), 64'd1);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (D + 2) step();
        check($sformatf("cfg%0d drained", gi), 64'(exp_q.size()), 64'd0);
        sweeps_done++;
      end
    end
  end

  initial begin
    m_rst_n = 1'b0; m_in_valid = 1'b0; m_out_ready = 1'b0;
    m_a = '0; m_b = '0; m_op = 2'd0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst out_valid", 64'(m_out_valid), 64'd0);
    check("rst out_y",     64'(m_y),         64'd0);
    check("rst out_pop",   64'(m_pop),       64'd0);
    check("rst out_zero",  64'(m_out_zero),  64'd1);
    check("rst txn_count", 64'(m_cnt),       64'd0);
    check("rst in_ready",  64'(m_in_ready),  64'd1);
    m_rst_n = 1'b1;

    // Ops: a=0100 b=1100, XOR/AND/OR/XNOR back to back
    m_out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) begin
        m_in_valid = 1'b1; m_a = 4'b0100; m_b = 4'b1100; m_op = T2_OP[i];
      end else begin
        m_in_valid = 1'b0;
      end
      step();
      if (i >= 1) begin
        check($sformatf("ops%0d out_valid", i - 1), 64'(m_out_valid), 64'd1);
        check($sformatf("ops%0d out_y", i - 1),     64'(m_y),         64'(T2_Y[i-1]));
        check($sformatf("ops%0d out_pop", i - 1),   64'(m_pop),       64'(T2_POP[i-1]));
      end
    end
    step();

    // Backpressure: two accepts fill the pipe, the third beat waits
    m_out_ready = 1'b0;
    for (int j = 0; j < 2; j++) begin
      m_in_valid = 1'b1; m_a = T3_A[j]; m_b = T3_B[j]; m_op = T3_OP[j];
      check($sformatf("bp accept%0d in_ready", j), 64'(m_in_ready), 64'd1);
      step();
    end
    m_a = T3_A[2]; m_b = T3_B[2]; m_op = T3_OP[2];
    repeat (3) begin
      check("bp full in_ready", 64'(m_in_ready),  64'd0);
      check("bp hold out_valid", 64'(m_out_valid), 64'd1);
      check("bp hold out_y",    64'(m_y),         64'b0001);
      step();
    end
    m_out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (k >= 1 && k < 3) begin
        m_a = T3_A[k+2]; m_b = T3_B[k+2]; m_op = T3_OP[k+2];
      end else if (k >= 3) begin
        m_in_valid = 1'b0;
      end
      #3;
      check($sformatf("bp drain%0d out_valid", k), 64'(m_out_valid), 64'd1);
      step();
    end
    step();

    // Zero flag
    m_in_valid = 1'b1; m_a = 4'b1010; m_b = 4'b1010; m_op = 2'd2;
    step();
    m_in_valid = 1'b0;
    step();
    check("zero out_valid", 64'(m_out_valid), 64'd1);
    check("zero out_y",     64'(m_y),         64'd0);
    check("zero out_zero",  64'(m_out_zero),  64'd1);
    check("zero out_pop",   64'(m_pop),       64'd0);
    step();

    // Reset mid-flight
    m_out_ready = 1'b0;
    repeat (2) begin
      m_in_valid = 1'b1; m_a = 4'($urandom()); m_b = 4'($urandom()); m_op = 2'($urandom());
      step();
    end
    m_in_valid = 1'b0;
    #1 m_rst_n = 1'b0;
    #1;
    check("midrst out_valid", 64'(m_out_valid), 64'd0);
    check("midrst txn_count", 64'(m_cnt),       64'd0);
    #1 m_rst_n = 1'b1;
    m_out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      check($sformatf("midrst idle%0d out_valid", c), 64'(m_out_valid), 64'd0);
    end

    // Counter wrap: 9 accepts on a 3-bit counter
    for (int n = 0; n < 9; n++) begin
      m_in_valid = 1'b1; m_a = 4'($urandom()); m_b = 4'($urandom()); m_op = 2'($urandom());
      step();
    end
    m_in_valid = 1'b0;
    check("wrap txn_count", 64'(m_cnt), 64'd1);
    repeat (4) step();

    for (int t = 0; t < 80000 && sweeps_done < 2; t++) @(posedge clk);
    check("sweeps finished", 64'(sweeps_done), 64'd2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
